// File: rtl/mmio_host_initiator.sv
// mmio_host_initiator
//   Host-side MMIO requester for the CCI-P MMIO path. Turns one command at a
//   time into a single-cycle MMIO write or read request pulse toward the AFU.
//   Reads carry a TID and complete when the AFU returns a response with the
//   same TID, or are abandoned with an error after TIMEOUT_CYCLES cycles of
//   waiting. At most one transaction is outstanding.
//
// Ports
//   clk, rst                     clock; asynchronous active-high reset
//   cmd_valid/cmd_ready          command handshake (ready only when idle)
//   cmd_write/cmd_addr/cmd_wdata command: 1=write, DWORD address, write data
//   done_valid/done_data/done_err one-cycle completion pulse, read data,
//                                timeout flag
//   mmio_wr_valid/mmio_rd_valid  one-cycle request pulses to the AFU
//   mmio_addr/mmio_tid/mmio_data request fields, held between requests
//   rsp_valid/rsp_tid/rsp_data   AFU read response
//   stray_cnt                    saturating count of unmatched responses
module mmio_host_initiator #(
   parameter int unsigned ADDR_W         = 16,
   parameter int unsigned TID_W          = 9,
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [63:0]       cmd_wdata,
   output logic              done_valid,
   output logic [63:0]       done_data,
   output logic              done_err,
   output logic              mmio_wr_valid,
   output logic              mmio_rd_valid,
   output logic [ADDR_W-1:0] mmio_addr,
   output logic [TID_W-1:0]  mmio_tid,
   output logic [63:0]       mmio_data,
   input  logic              rsp_valid,
   input  logic [TID_W-1:0]  rsp_tid,
   input  logic [63:0]       rsp_data,
   output logic [7:0]        stray_cnt
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]        state_q,      state_d;
   logic              cmd_ready_q,  cmd_ready_d;
   logic              is_write_q,   is_write_d;
   logic              wr_valid_q,   wr_valid_d;
   logic              rd_valid_q,   rd_valid_d;
   logic [ADDR_W-1:0] addr_q,       addr_d;
   logic [TID_W-1:0]  tid_q,        tid_d;
   logic [63:0]       data_q,       data_d;
   logic [TID_W-1:0]  tid_cnt_q,    tid_cnt_d;
   logic [CNT_W-1:0]  to_cnt_q,     to_cnt_d;
   logic              done_valid_q, done_valid_d;
   logic [63:0]       done_data_q,  done_data_d;
   logic              done_err_q,   done_err_d;
   logic [7:0]        stray_q,      stray_d;
   logic              rsp_match;

   // Only a response seen while waiting, carrying the issued TID, completes a read.
   assign rsp_match = rsp_valid && (state_q == S_WAIT) && (rsp_tid == tid_q);

   always_comb begin
      state_d      = state_q;
      is_write_d   = is_write_q;
      wr_valid_d   = 1'b0;
      rd_valid_d   = 1'b0;
      addr_d       = addr_q;
      tid_d        = tid_q;
      data_d       = data_q;
      tid_cnt_d    = tid_cnt_q;
      to_cnt_d     = to_cnt_q;
      done_valid_d = 1'b0;
      done_data_d  = done_data_q;
      done_err_d   = 1'b0;
      stray_d      = stray_q;

      case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               addr_d     = cmd_addr;
               data_d     = cmd_wdata;
               is_write_d = cmd_write;
               tid_d      = tid_cnt_q;
               wr_valid_d = cmd_write;
               rd_valid_d = !cmd_write;
               state_d    = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (is_write_q) begin
               done_valid_d = 1'b1;
               done_data_d  = '0;
               state_d      = S_DONE;
            end else begin
               to_cnt_d  = '0;
               tid_cnt_d = tid_cnt_q + TID_W'(1);
               state_d   = S_WAIT;
            end
         end
         S_WAIT: begin
            // A match on the final wait cycle still beats the timeout.
            if (rsp_match) begin
               done_valid_d = 1'b1;
               done_data_d  = rsp_data;
               state_d      = S_DONE;
            end else if (to_cnt_q == CNT_LAST) begin
               done_valid_d = 1'b1;
               done_data_d  = '0;
               done_err_d   = 1'b1;
               state_d      = S_DONE;
            end else begin
               to_cnt_d = to_cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (rsp_valid && !rsp_match && (stray_q != 8'hFF)) begin
         stray_d = stray_q + 8'd1;
      end

      cmd_ready_d = (state_d == S_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         cmd_ready_q  <= 1'b1;
         is_write_q   <= 1'b0;
         wr_valid_q   <= 1'b0;
         rd_valid_q   <= 1'b0;
         addr_q       <= '0;
         tid_q        <= '0;
         data_q       <= '0;
         tid_cnt_q    <= '0;
         to_cnt_q     <= '0;
         done_valid_q <= 1'b0;
         done_data_q  <= '0;
         done_err_q   <= 1'b0;
         stray_q      <= '0;
      end else begin
         state_q      <= state_d;
         cmd_ready_q  <= cmd_ready_d;
         is_write_q   <= is_write_d;
         wr_valid_q   <= wr_valid_d;
         rd_valid_q   <= rd_valid_d;
         addr_q       <= addr_d;
         tid_q        <= tid_d;
         data_q       <= data_d;
         tid_cnt_q    <= tid_cnt_d;
         to_cnt_q     <= to_cnt_d;
         done_valid_q <= done_valid_d;
         done_data_q  <= done_data_d;
         done_err_q   <= done_err_d;
         stray_q      <= stray_d;
      end
   end

   assign cmd_ready     = cmd_ready_q;
   assign done_valid    = done_valid_q;
   assign done_data     = done_data_q;
   assign done_err      = done_err_q;
   assign mmio_wr_valid = wr_valid_q;
   assign mmio_rd_valid = rd_valid_q;
   assign mmio_addr     = addr_q;
   assign mmio_tid      = tid_q;
   assign mmio_data     = data_q;
   assign stray_cnt     = stray_q;

endmodule

// File: tb/tb_mmio_host_initiator.sv
// Bench for mmio_host_initiator: directed scenarios plus randomized traffic,
// predicted from a transaction-level model (TID sequence, response window,
// stray tally).
module tb_mmio_host_initiator;

   localparam int T = 256;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [15:0] cmd_addr;
   logic [63:0] cmd_wdata;
   logic        done_valid, done_err;
   logic [63:0] done_data;
   logic        mmio_wr_valid, mmio_rd_valid;
   logic [15:0] mmio_addr;
   logic [8:0]  mmio_tid;
   logic [63:0] mmio_data;
   logic        rsp_valid;
   logic [8:0]  rsp_tid;
   logic [63:0] rsp_data;
   logic [7:0]  stray_cnt;

   mmio_host_initiator #(.ADDR_W(16), .TID_W(9), .TIMEOUT_CYCLES(T)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .done_valid(done_valid), .done_data(done_data), .done_err(done_err),
      .mmio_wr_valid(mmio_wr_valid), .mmio_rd_valid(mmio_rd_valid),
      .mmio_addr(mmio_addr), .mmio_tid(mmio_tid), .mmio_data(mmio_data),
      .rsp_valid(rsp_valid), .rsp_tid(rsp_tid), .rsp_data(rsp_data),
      .stray_cnt(stray_cnt)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state
   int unsigned exp_tid      = 0;
   int unsigned stray_events = 0;

   // Observations from the last transaction
   int          o_lat, o_wr_pulses, o_rd_pulses, o_issue_k;
   logic [15:0] o_addr;
   logic [8:0]  o_tid;
   logic [63:0] o_data, o_ddata;
   logic        o_derr, o_ready_bad, o_hung;
   logic        o_after_valid, o_after_err, o_after_ready;

   function automatic int unsigned exp_stray();
      return (stray_events > 255) ? 255 : stray_events;
   endfunction

   // Cycle (counted from the accept edge) at which a correct response is
   // presented; 0 if none.
   function automatic int rsp_k(int d, bit wrong);
      if (d == 0) return 0;
      return wrong ? d + 2 : d + 1;
   endfunction

   // A read completes one cycle after a correct response presented while
   // waiting (cycles 2..T+1); otherwise it times out and completes at T+2.
   function automatic int pred_lat(bit wr, int d, bit wrong);
      int k;
      if (wr) return 2;
      k = rsp_k(d, wrong);
      if (k >= 2 && k <= T + 1) return k + 1;
      return T + 2;
   endfunction

   function automatic bit pred_err(bit wr, int d, bit wrong);
      int k;
      if (wr) return 1'b0;
      k = rsp_k(d, wrong);
      return !(k >= 2 && k <= T + 1);
   endfunction

   // Drives one command and an optional response; records observations only.
   task automatic xact(input bit wr, input logic [15:0] a, input logic [63:0] wd,
                       input int d, input logic [63:0] rd, input bit wrong_first);
      int k;
      bit got;
      logic [8:0] flip;
      o_lat = -1; o_wr_pulses = 0; o_rd_pulses = 0; o_issue_k = -1;
      o_addr = '0; o_tid = '0; o_data = '0; o_ddata = '0; o_derr = 1'b0;
      o_ready_bad = 1'b0; o_hung = 1'b0;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = wd;
      @(negedge clk);
      cmd_valid = 1'b0; cmd_write = 1'($urandom); cmd_addr = 16'($urandom);
      cmd_wdata = {$urandom, $urandom};
      k = 1; got = 1'b0;
      while (!got && k < 2 * T + 40) begin
         rsp_valid = 1'b0;
         if (mmio_wr_valid) begin
            o_wr_pulses++; o_addr = mmio_addr; o_data = mmio_data; o_issue_k = k;
         end
         if (mmio_rd_valid) begin
            o_rd_pulses++; o_addr = mmio_addr; o_tid = mmio_tid; o_issue_k = k;
         end
         if (done_valid) begin
            got = 1'b1; o_lat = k; o_ddata = done_data; o_derr = done_err;
         end else if (cmd_ready !== 1'b0) begin
            o_ready_bad = 1'b1;
         end
         if (!wr && d > 0) begin
            if (wrong_first && k == d + 1) begin
               flip = 9'($urandom_range(1, 511));
               rsp_valid = 1'b1; rsp_tid = o_tid ^ flip; rsp_data = {$urandom, $urandom};
               stray_events++;
            end
            if (k == rsp_k(d, wrong_first)) begin
               rsp_valid = 1'b1; rsp_tid = 9'(exp_tid); rsp_data = rd;
               if (!(k >= 2 && k <= T + 1)) stray_events++;
            end
         end
         if (!got) begin
            @(negedge clk);
            k++;
         end
      end
      if (!got) o_hung = 1'b1;
      @(negedge clk);
      rsp_valid = 1'b0;
      o_after_valid = done_valid; o_after_err = done_err; o_after_ready = cmd_ready;
      if (!wr) exp_tid = (exp_tid + 1) % 512;
   endtask

   task automatic test_reset();
      rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
      rsp_valid = 1'b0; rsp_tid = '0; rsp_data = '0;
      repeat (3) @(negedge clk);
      n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", cmd_ready); end
      n_checks++; if ({done_valid, done_err, mmio_wr_valid, mmio_rd_valid} !== 4'b0) begin
         n_fail++; $display("FAIL reset_pulses: got %b expected 0000", {done_valid, done_err, mmio_wr_valid, mmio_rd_valid}); end
      n_checks++; if ({done_data, mmio_data, mmio_addr, mmio_tid} !== '0) begin
         n_fail++; $display("FAIL reset_data: got %h/%h/%h/%h expected 0", done_data, mmio_data, mmio_addr, mmio_tid); end
      n_checks++; if (stray_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_stray: got %0d expected 0", stray_cnt); end
      rst = 1'b0;
      @(negedge clk);
      n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_ready: got %b expected 1", cmd_ready); end
   endtask

   task automatic test_write();
      xact(1'b1, 16'h0020, 64'h1234_5678_9ABC_DEF0, 0, '0, 1'b0);
      n_checks++; if (o_wr_pulses !== 1 || o_rd_pulses !== 0 || o_issue_k !== 1) begin
         n_fail++; $display("FAIL write_pulse: got wr=%0d rd=%0d at %0d expected wr=1 rd=0 at 1", o_wr_pulses, o_rd_pulses, o_issue_k); end
      n_checks++; if (o_addr !== 16'h0020 || o_data !== 64'h1234_5678_9ABC_DEF0) begin
         n_fail++; $display("FAIL write_fields: got %h/%h expected 0020/123456789abcdef0", o_addr, o_data); end
      n_checks++; if (o_lat !== 2) begin n_fail++; $display("FAIL write_latency: got %0d expected 2", o_lat); end
      n_checks++; if (o_ddata !== '0 || o_derr !== 1'b0) begin
         n_fail++; $display("FAIL write_done: got data=%h err=%b expected 0/0", o_ddata, o_derr); end
      n_checks++; if (o_ready_bad || o_after_valid !== 1'b0 || o_after_ready !== 1'b1) begin
         n_fail++; $display("FAIL write_handshake: got busy_bad=%b after_valid=%b after_ready=%b expected 0/0/1", o_ready_bad, o_after_valid, o_after_ready); end
      n_checks++; if (mmio_addr !== 16'h0020 || mmio_data !== 64'h1234_5678_9ABC_DEF0) begin
         n_fail++; $display("FAIL write_hold: got %h/%h expected held values", mmio_addr, mmio_data); end
   endtask

   task automatic test_read_echo();
      int unsigned et;
      et = exp_tid;
      xact(1'b0, 16'h0020, '0, 1, 64'hA5A5, 1'b0);
      n_checks++; if (o_rd_pulses !== 1 || o_wr_pulses !== 0 || o_tid !== 9'(et) || o_addr !== 16'h0020) begin
         n_fail++; $display("FAIL read_issue: got rd=%0d wr=%0d tid=%0d addr=%h expected 1/0/%0d/0020", o_rd_pulses, o_wr_pulses, o_tid, o_addr, et); end
      n_checks++; if (o_lat !== 3 || o_ddata !== 64'hA5A5 || o_derr !== 1'b0) begin
         n_fail++; $display("FAIL read_done: got lat=%0d data=%h err=%b expected 3/a5a5/0", o_lat, o_ddata, o_derr); end
      et = exp_tid;
      xact(1'b0, 16'h0024, '0, 1, 64'h77, 1'b0);
      n_checks++; if (o_tid !== 9'(et) || o_ddata !== 64'h77) begin
         n_fail++; $display("FAIL read_next_tid: got tid=%0d data=%h expected %0d/77", o_tid, o_ddata, et); end
   endtask

   task automatic test_timeout();
      logic [8:0] t;
      xact(1'b0, 16'h0100, '0, 0, '0, 1'b0);
      t = o_tid;
      n_checks++; if (o_lat !== T + 2 || o_derr !== 1'b1 || o_ddata !== '0) begin
         n_fail++; $display("FAIL timeout_done: got lat=%0d err=%b data=%h expected %0d/1/0", o_lat, o_derr, o_ddata, T + 2); end
      n_checks++; if (o_after_err !== 1'b0 || o_after_valid !== 1'b0) begin
         n_fail++; $display("FAIL timeout_clear: got valid=%b err=%b expected 0/0", o_after_valid, o_after_err); end
      @(negedge clk); rsp_valid = 1'b1; rsp_tid = t; rsp_data = 64'hDEAD; stray_events++;
      @(negedge clk); rsp_valid = 1'b0;
      n_checks++; if (stray_cnt !== 8'(exp_stray())) begin
         n_fail++; $display("FAIL late_stray: got %0d expected %0d", stray_cnt, exp_stray()); end
      // Response on the last waiting cycle still completes the read.
      xact(1'b0, 16'h0104, '0, T, 64'hBEEF, 1'b0);
      n_checks++; if (o_lat !== pred_lat(1'b0, T, 1'b0) || o_derr !== 1'b0 || o_ddata !== 64'hBEEF) begin
         n_fail++; $display("FAIL last_cycle_match: got lat=%0d err=%b data=%h expected %0d/0/beef", o_lat, o_derr, o_ddata, pred_lat(1'b0, T, 1'b0)); end
      // One cycle later is too late.
      xact(1'b0, 16'h0108, '0, T + 1, 64'hBEEF, 1'b0);
      n_checks++; if (o_lat !== pred_lat(1'b0, T + 1, 1'b0) || o_derr !== 1'b1 || o_ddata !== '0) begin
         n_fail++; $display("FAIL one_late: got lat=%0d err=%b data=%h expected %0d/1/0", o_lat, o_derr, o_ddata, pred_lat(1'b0, T + 1, 1'b0)); end
      @(negedge clk);
      n_checks++; if (stray_cnt !== 8'(exp_stray())) begin
         n_fail++; $display("FAIL one_late_stray: got %0d expected %0d", stray_cnt, exp_stray()); end
   endtask

   task automatic test_wrong_tid();
      xact(1'b0, 16'h0200, '0, 2, 64'hCAFE_F00D, 1'b1);
      n_checks++; if (o_lat !== 5 || o_derr !== 1'b0 || o_ddata !== 64'hCAFE_F00D) begin
         n_fail++; $display("FAIL wrong_tid_done: got lat=%0d err=%b data=%h expected 5/0/cafef00d", o_lat, o_derr, o_ddata); end
      n_checks++; if (stray_cnt !== 8'(exp_stray())) begin
         n_fail++; $display("FAIL wrong_tid_stray: got %0d expected %0d", stray_cnt, exp_stray()); end
   endtask

   task automatic test_random_mix();
      bit wr, wrong;
      int d;
      int unsigned et;
      logic [15:0] a;
      logic [63:0] wd, rd;
      for (int i = 0; i < 40; i++) begin
         wr = 1'($urandom); wrong = 1'($urandom); d = $urandom_range(1, 8);
         a = 16'($urandom); wd = {$urandom, $urandom}; rd = {$urandom, $urandom};
         et = exp_tid;
         xact(wr, a, wd, d, rd, wrong);
         n_checks++; if (o_addr !== a || (wr ? (o_data !== wd || o_wr_pulses !== 1 || o_rd_pulses !== 0)
                                            : (o_tid !== 9'(et) || o_rd_pulses !== 1 || o_wr_pulses !== 0))) begin
            n_fail++; $display("FAIL rand_issue[%0d]: got addr=%h tid=%0d data=%h wr=%0d rd=%0d expected addr=%h tid=%0d data=%h write=%b",
                               i, o_addr, o_tid, o_data, o_wr_pulses, o_rd_pulses, a, et, wd, wr); end
         n_checks++; if (o_hung || o_lat !== pred_lat(wr, d, wrong) || o_derr !== pred_err(wr, d, wrong)) begin
            n_fail++; $display("FAIL rand_timing[%0d]: got lat=%0d err=%b expected %0d/%b", i, o_lat, o_derr, pred_lat(wr, d, wrong), pred_err(wr, d, wrong)); end
         n_checks++; if (o_ddata !== (wr ? 64'h0 : rd)) begin
            n_fail++; $display("FAIL rand_data[%0d]: got %h expected %h", i, o_ddata, wr ? 64'h0 : rd); end
         n_checks++; if (stray_cnt !== 8'(exp_stray()) || o_ready_bad || o_after_ready !== 1'b1) begin
            n_fail++; $display("FAIL rand_misc[%0d]: got stray=%0d busy_bad=%b after_ready=%b expected %0d/0/1", i, stray_cnt, o_ready_bad, o_after_ready, exp_stray()); end
      end
   endtask

   task automatic test_tid_wrap();
      int unsigned et;
      int wraps = 0;
      logic [63:0] rd;
      for (int i = 0; i < 520; i++) begin
         et = exp_tid;
         rd = {$urandom, $urandom};
         xact(1'b0, 16'(i), '0, 1, rd, 1'b0);
         if (et == 0 && i > 0) wraps++;
         n_checks++; if (o_tid !== 9'(et) || o_derr !== 1'b0 || o_ddata !== rd || o_lat !== 3) begin
            n_fail++; $display("FAIL wrap_read[%0d]: got tid=%0d err=%b data=%h lat=%0d expected %0d/0/%h/3", i, o_tid, o_derr, o_ddata, o_lat, et, rd); end
         n_checks++; if (o_ready_bad || o_after_ready !== 1'b1 || o_after_valid !== 1'b0) begin
            n_fail++; $display("FAIL wrap_ready[%0d]: got busy_bad=%b after_ready=%b after_valid=%b expected 0/1/0", i, o_ready_bad, o_after_ready, o_after_valid); end
      end
      n_checks++; if (wraps < 1) begin n_fail++; $display("FAIL wrap_seen: got %0d wraps expected at least 1", wraps); end
   endtask

   task automatic test_stray_saturate();
      for (int i = 0; i < 300; i++) begin
         @(negedge clk); rsp_valid = 1'b1; rsp_tid = 9'($urandom); rsp_data = {$urandom, $urandom};
         stray_events++;
      end
      @(negedge clk); rsp_valid = 1'b0;
      n_checks++; if (stray_cnt !== 8'(exp_stray())) begin
         n_fail++; $display("FAIL stray_saturate: got %0d expected %0d", stray_cnt, exp_stray()); end
      n_checks++; if (done_valid !== 1'b0 || cmd_ready !== 1'b1) begin
         n_fail++; $display("FAIL stray_idle: got valid=%b ready=%b expected 0/1", done_valid, cmd_ready); end
   endtask

   task automatic test_reset_mid();
      bit saw_done = 1'b0;
      @(negedge clk); cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 16'h0040;
      @(negedge clk); cmd_valid = 1'b0;
      repeat (4) @(negedge clk);
      n_checks++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL mid_busy: got %b expected 0", cmd_ready); end
      #2 rst = 1'b1;
      #1;
      n_checks++; if (cmd_ready !== 1'b1 || stray_cnt !== 8'd0) begin
         n_fail++; $display("FAIL mid_reset_state: got ready=%b stray=%0d expected 1/0", cmd_ready, stray_cnt); end
      n_checks++; if ({done_valid, done_err, mmio_wr_valid, mmio_rd_valid} !== 4'b0 ||
                      {done_data, mmio_data, mmio_addr, mmio_tid} !== '0) begin
         n_fail++; $display("FAIL mid_reset_outputs: got %b %h %h %h %h expected all 0",
                            {done_valid, done_err, mmio_wr_valid, mmio_rd_valid}, done_data, mmio_data, mmio_addr, mmio_tid); end
      exp_tid = 0; stray_events = 0;
      repeat (3) begin @(negedge clk); if (done_valid) saw_done = 1'b1; end
      rst = 1'b0;
      repeat (10) begin @(negedge clk); if (done_valid) saw_done = 1'b1; end
      n_checks++; if (saw_done !== 1'b0) begin n_fail++; $display("FAIL mid_no_done: got done pulse expected none"); end
      xact(1'b0, 16'h0044, '0, 1, 64'h1122, 1'b0);
      n_checks++; if (o_tid !== 9'd0 || o_ddata !== 64'h1122 || o_derr !== 1'b0) begin
         n_fail++; $display("FAIL mid_next_read: got tid=%0d data=%h err=%b expected 0/1122/0", o_tid, o_ddata, o_derr); end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read_echo();
      test_timeout();
      test_wrong_tid();
      test_random_mix();
      test_tid_wrap();
      test_stray_saturate();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
